// File: rtl/tx_frame_ctrl.sv
// Transmit framing controller: accepts one byte per valid/ready handshake and sequences the
// load/shift strobes of an external MSB-first shift register for a {0, data, 1} frame.
module tx_frame_ctrl #(
  parameter int unsigned BIT_PERIOD = 10,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS+1:0] parallel_out,
  output logic                 load_enable,
  output logic                 shift_enable,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam int unsigned FRAME_BITS = DATA_BITS + 2;
  localparam int unsigned TimerW     = $clog2(BIT_PERIOD);
  localparam int unsigned CntW       = $clog2(FRAME_BITS);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(BIT_PERIOD - 1);
  localparam logic [TimerW-1:0] TimerPre  = TimerW'(BIT_PERIOD - 2);
  localparam logic [CntW-1:0]   CntLast   = CntW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } state_e;

  state_e            state;
  logic [TimerW-1:0] timer;
  logic [CntW-1:0]   bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      timer        <= '0;
      bit_cnt      <= '0;
      parallel_out <= '1;
      tx_ready     <= 1'b1;
      tx_busy      <= 1'b0;
      load_enable  <= 1'b0;
      shift_enable <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      load_enable  <= 1'b0;
      shift_enable <= 1'b0;
      frame_done   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (tx_valid && tx_ready) begin
            parallel_out <= {1'b0, tx_data, 1'b1};
            timer        <= '0;
            bit_cnt      <= '0;
            tx_ready     <= 1'b0;
            tx_busy      <= 1'b1;
            load_enable  <= 1'b1;
            state        <= StLoad;
          end
        end
        StLoad: begin
          state <= StShift;
        end
        StShift: begin
          if (timer == TimerLast) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CntLast) begin
              state    <= StIdle;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
          // Strobes are registered one cycle ahead so they are high while timer == BIT_PERIOD-1.
          if (timer == TimerPre) begin
            shift_enable <= 1'b1;
            frame_done   <= (bit_cnt == CntLast);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: a BIT_PERIOD=4 instance and a BIT_PERIOD=2 instance, each
// feeding a behavioural MSB-first shift register whose serial bit is checked on every shift.
module tb_tx_frame_ctrl;

  localparam int Fb = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tx_valid, tx_ready, load_enable, shift_enable, tx_busy, frame_done;
  logic [7:0] tx_data      [2];
  logic [9:0] parallel_out [2];
  logic [9:0] sr           [2];

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  logic       exp_bits   [2][$];
  logic [9:0] exp_frames [2][$];
  int         last_evt   [2];
  int         shift_idx  [2];
  int         n_loads    [2];

  always #5 clk = ~clk;

  tx_frame_ctrl #(.BIT_PERIOD(4), .DATA_BITS(8)) dut4 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .parallel_out(parallel_out[0]), .load_enable(load_enable[0]),
    .shift_enable(shift_enable[0]), .tx_busy(tx_busy[0]), .frame_done(frame_done[0])
  );

  tx_frame_ctrl #(.BIT_PERIOD(2), .DATA_BITS(8)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .parallel_out(parallel_out[1]), .load_enable(load_enable[1]),
    .shift_enable(shift_enable[1]), .tx_busy(tx_busy[1]), .frame_done(frame_done[1])
  );

  function automatic int period(input int g);
    return (g == 0) ? 4 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: event not expected here (cycle %0d)", name, cyc);
  endtask

  // Behavioural external shift register: MSB-first, fill 1, reset from the same source.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (rst) sr[g] <= '1;
      else if (load_enable[g]) sr[g] <= parallel_out[g];
      else if (shift_enable[g]) sr[g] <= {sr[g][8:0], 1'b1};
    end
  end

  // Monitor: pops expectations whenever a strobe appears.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (load_enable[g] === 1'b1) begin
        n_loads[g]++;
        last_evt[g]  = cyc;
        shift_idx[g] = 0;
        if (exp_frames[g].size() == 0) fail_now("unexpected_load");
        else check("load_frame", parallel_out[g], exp_frames[g].pop_front());
      end
      if (shift_enable[g] === 1'b1) begin
        check("shift_spacing", cyc - last_evt[g], period(g));
        check("no_overlap", load_enable[g], 0);
        check("frame_done_align", frame_done[g], shift_idx[g] == Fb - 1);
        if (exp_bits[g].size() == 0) fail_now("unexpected_shift");
        else check("serial_bit", sr[g][9], exp_bits[g].pop_front());
        last_evt[g] = cyc;
        shift_idx[g]++;
      end else if (frame_done[g] === 1'b1) begin
        fail_now("done_without_shift");
      end
    end
  end

  task automatic push_frame(input int g, input logic [9:0] frame);
    exp_frames[g].push_back(frame);
    for (int i = 9; i >= 0; i--) exp_bits[g].push_back(frame[i]);
  endtask

  // Entered at a negedge; returns at the negedge right after the handshake edge.
  task automatic send(input int g, input logic [7:0] d, input logic [9:0] frame, output int hs);
    push_frame(g, frame);
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready[g]) begin
        @(negedge clk);
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    tx_valid[g] = 1'b0;
    if (hs < 0) fail_now("handshake_timeout");
    else check("latched_frame", parallel_out[g], frame);
  endtask

  task automatic wait_ready(input int g, input logic val, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready[g] == val) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) fail_now("ready_timeout");
  endtask

  task automatic wait_done(input int g, input int hs, input int total);
    int d = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done[g]) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) begin
      fail_now("done_timeout");
    end else begin
      check("frame_length", d + 1 - hs, total);
      @(negedge clk);
      check("ready_after_done", tx_ready[g], 1);
      check("line_idle", sr[g][9], 1);
    end
  endtask

  task automatic check_reset_state(input int g);
    check("rst_ready", tx_ready[g], 1);
    check("rst_busy", tx_busy[g], 0);
    check("rst_load", load_enable[g], 0);
    check("rst_shift", shift_enable[g], 0);
    check("rst_done", frame_done[g], 0);
    check("rst_parallel", parallel_out[g], 10'h3FF);
  endtask

  initial begin
    int hs, hs1, hs2, at, loads_before;
    for (int g = 0; g < 2; g++) begin
      last_evt[g]  = 0;
      shift_idx[g] = 0;
      n_loads[g]   = 0;
      tx_data[g]   = 8'h55;
    end
    rst      = 1'b1;
    tx_valid = 2'b11;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) check_reset_state(g);
    tx_valid = 2'b00;
    rst      = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame A5
    send(0, 8'hA5, 10'h14B, hs);
    wait_done(0, hs, 41);

    // Valid pulsed mid-frame is ignored
    send(0, 8'h3C, 10'h079, hs);
    repeat (10) @(negedge clk);
    tx_data[0]  = 8'hFF;
    tx_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    tx_valid[0] = 1'b0;
    check("frame_held", parallel_out[0], 10'h079);
    loads_before = n_loads[0];
    wait_done(0, hs, 41);
    repeat (5) @(negedge clk);
    check("no_extra_load", n_loads[0], loads_before);

    // Back-to-back 00 then FF with tx_valid held
    push_frame(0, 10'h001);
    push_frame(0, 10'h1FF);
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    wait_ready(0, 1'b0, hs1);
    tx_data[0] = 8'hFF;
    wait_ready(0, 1'b1, at);
    check("gap_line_stop", sr[0][9], 1);
    check("gap_busy", tx_busy[0], 0);
    wait_ready(0, 1'b0, hs2);
    tx_valid[0] = 1'b0;
    check("b2b_load_spacing", hs2 - hs1, 42);
    wait_done(0, hs2, 41);

    // Reset during the 5th bit of 81, then resend
    send(0, 8'h81, 10'h103, hs);
    repeat (18) @(negedge clk);
    check("pre_reset_shifts", shift_idx[0], 4);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state(0);
    check("rst_line", sr[0][9], 1);
    rst = 1'b0;
    exp_bits[0].delete();
    exp_frames[0].delete();
    shift_idx[0] = 0;
    loads_before = n_loads[0];
    repeat (8) @(negedge clk);
    check("post_reset_quiet", n_loads[0], loads_before);
    send(0, 8'h81, 10'h103, hs);
    wait_done(0, hs, 41);

    // Minimum bit period
    send(1, 8'h01, 10'h003, hs);
    wait_done(1, hs, 21);

    for (int g = 0; g < 2; g++) begin
      check("bits_drained", exp_bits[g].size(), 0);
      check("frames_drained", exp_frames[g].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
